// File: rtl/pixel_dispatcher.sv
// Raster-walks one frame, feeding each pixel's c = (re, im) to a depth engine and streaming depth out.
// calc_start 1 cycle after accept/handshake, pix_valid 1 cycle after calc_done; pix_* held until pix_ready.
module pixel_dispatcher #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int FRAC   = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [31:0] re_origin,
    input  logic [31:0] im_origin,
    input  logic [31:0] step,
    output logic        busy,
    output logic        calc_start,
    output logic [9:0]  calc_x,
    output logic [8:0]  calc_y,
    output logic [31:0] calc_re_c,
    output logic [31:0] calc_im_c,
    input  logic        calc_done,
    input  logic [9:0]  calc_depth,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [9:0]  pix_depth,
    output logic        pix_last
);

    if (WIDTH < 1 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 512 || FRAC < 0 || FRAC > 31) begin : g_cfg_err
        $error("pixel_dispatcher: unsupported geometry or fraction width");
    end

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_re_org;
    logic [31:0] r_step;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [31:0] r_re_c;
    logic [31:0] r_im_c;
    logic [9:0]  r_pix_x;
    logic [8:0]  r_pix_y;
    logic [9:0]  r_pix_depth;
    logic        r_pix_last;

    logic        w_handshake;
    logic        w_x_end;

    assign w_handshake = (r_state == S_OUTPUT) && pix_ready;
    assign w_x_end     = (r_x == X_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (frame_start) w_next_state = S_ISSUE;
            S_ISSUE:  w_next_state = S_WAIT;
            S_WAIT:   if (calc_done) w_next_state = S_OUTPUT;
            S_OUTPUT: if (pix_ready) w_next_state = r_pix_last ? S_IDLE : S_ISSUE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Control outputs decode only the state register, so no input reaches them combinationally.
    always_comb begin
        busy       = (r_state != S_IDLE);
        calc_start = (r_state == S_ISSUE);
        pix_valid  = (r_state == S_OUTPUT);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_re_org    <= '0;
            r_step      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_re_c      <= '0;
            r_im_c      <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_depth <= '0;
            r_pix_last  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && frame_start) begin
                r_re_org <= re_origin;
                r_step   <= step;
                r_x      <= '0;
                r_y      <= '0;
                r_re_c   <= re_origin;
                r_im_c   <= im_origin;
            end
            if (r_state == S_WAIT && calc_done) begin
                r_pix_depth <= calc_depth;
                r_pix_x     <= r_x;
                r_pix_y     <= r_y;
                r_pix_last  <= w_x_end && (r_y == Y_LAST);
            end
            if (w_handshake) begin
                r_pix_last <= 1'b0;
                if (!r_pix_last) begin
                    // Screen y grows downward while the imaginary axis decreases.
                    if (w_x_end) begin
                        r_x    <= '0;
                        r_y    <= r_y + 9'd1;
                        r_re_c <= r_re_org;
                        r_im_c <= r_im_c - r_step;
                    end else begin
                        r_x    <= r_x + 10'd1;
                        r_re_c <= r_re_c + r_step;
                    end
                end
            end
        end
    end

    assign calc_x    = r_x;
    assign calc_y    = r_y;
    assign calc_re_c = r_re_c;
    assign calc_im_c = r_im_c;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_depth = r_pix_depth;
    assign pix_last  = r_pix_last;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x3 frame with a stub depth engine and a coordinate-arithmetic model.
module tb_pixel_dispatcher;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] re_origin = '0;
    logic [31:0] im_origin = '0;
    logic [31:0] step = '0;
    logic        busy;
    logic        calc_start;
    logic [9:0]  calc_x;
    logic [8:0]  calc_y;
    logic [31:0] calc_re_c;
    logic [31:0] calc_im_c;
    logic        calc_done;
    logic [9:0]  calc_depth;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [9:0]  pix_depth;
    logic        pix_last;

    pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .FRAC(16)) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .busy(busy), .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
        .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
        .calc_done(calc_done), .calc_depth(calc_depth),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth), .pix_last(pix_last)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endfunction

    // Stub engine: done drops after start, returns depth x+4y after a chosen latency.
    int          lat = 1;
    bit          rand_lat = 1'b0;
    int          eng_cnt;
    logic [9:0]  eng_x;
    logic [8:0]  eng_y;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            calc_done  <= 1'b0;
            calc_depth <= '0;
            eng_cnt    <= 0;
            eng_x      <= '0;
            eng_y      <= '0;
        end else if (calc_start) begin
            calc_done <= 1'b0;
            eng_cnt   <= rand_lat ? int'($urandom_range(1, 6)) : lat;
            eng_x     <= calc_x;
            eng_y     <= calc_y;
        end else if (!calc_done && eng_cnt != 0) begin
            if (eng_cnt == 1) begin
                calc_done  <= 1'b1;
                calc_depth <= 10'(32'(eng_x) + 4 * 32'(eng_y));
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Reference model: pixel i sits at (i%W, i/W); c = origin + x*step, im = im_origin - y*step.
    logic [31:0] m_re0, m_im0, m_step;
    int          m_start_idx = 0;
    int          m_pix_idx = 0;
    bit          busy_chk = 1'b0;

    function automatic logic [31:0] exp_re(input int i);
        return m_re0 + m_step * 32'(i % W);
    endfunction

    function automatic logic [31:0] exp_im(input int i);
        return m_im0 - m_step * 32'(i / W);
    endfunction

    always @(negedge sysclk) begin
        if (!reset) begin
            if (busy_chk) begin
                chk("busy_after_last", {31'd0, busy}, 32'd0);
                busy_chk = 1'b0;
            end
            if (calc_start) begin
                chk("start_x",  32'(calc_x),  32'(m_start_idx % W));
                chk("start_y",  32'(calc_y),  32'(m_start_idx / W));
                chk("start_re", calc_re_c,    exp_re(m_start_idx));
                chk("start_im", calc_im_c,    exp_im(m_start_idx));
                m_start_idx++;
            end
            if (pix_valid && pix_ready) begin
                chk("pix_x",     32'(pix_x),     32'(m_pix_idx % W));
                chk("pix_y",     32'(pix_y),     32'(m_pix_idx / W));
                chk("pix_depth", 32'(pix_depth), 32'((m_pix_idx % W) + 4 * (m_pix_idx / W)));
                chk("pix_last",  {31'd0, pix_last}, {31'd0, m_pix_idx == NPIX - 1});
                chk("held_re",   calc_re_c,      exp_re(m_pix_idx));
                chk("held_im",   calc_im_c,      exp_im(m_pix_idx));
                if (m_pix_idx == NPIX - 1) busy_chk = 1'b1;
                m_pix_idx++;
            end
        end
    end

    task automatic start_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        m_re0 = a; m_im0 = b; m_step = c;
        m_start_idx = 0; m_pix_idx = 0;
        @(posedge sysclk); #2;
        re_origin = a; im_origin = b; step = c; frame_start = 1'b1;
        @(posedge sysclk); #2;
        frame_start = 1'b0;
        @(negedge sysclk);
        chk("start_latency", {31'd0, calc_start}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge sysclk); #2;
            pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        pix_ready = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        chk("n_pixels", 32'(m_pix_idx), 32'(NPIX));
        chk("n_starts", 32'(m_start_idx), 32'(NPIX));
    endtask

    initial begin
        int n;
        bit found;

        // Reset state
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_ctl", {28'd0, busy, calc_start, pix_valid, pix_last}, 32'd0);
        chk("rst_calc_re", calc_re_c, 32'd0);
        chk("rst_calc_im", calc_im_c, 32'd0);
        chk("rst_pix", {3'd0, pix_depth, pix_x, pix_y}, 32'd0);
        @(posedge sysclk); #2 reset = 1'b0;

        // Raster walk, engine latency 1, always ready
        lat = 1;
        start_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
        wait_idle(200, 1'b0);

        // Slow engine
        lat = 1000;
        start_frame(32'h00001234, 32'hFFFF0000, 32'h00000400);
        wait_idle(14000, 1'b0);

        // Random values, random latency, random backpressure
        rand_lat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_frame($urandom, $urandom, $urandom);
            wait_idle(2000, 1'b1);
        end
        rand_lat = 1'b0;
        lat = 1;

        // Backpressure on pixel (2,1)
        start_frame(32'h00020000, 32'h00030000, 32'h00001000);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge sysclk);
            if (calc_start && calc_x == 10'd2 && calc_y == 9'd1) found = 1'b1;
            n++;
        end
        chk("bp_reach_pixel", {31'd0, found}, 32'd1);
        @(posedge sysclk); #2 pix_ready = 1'b0;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!pix_valid && n < 50);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, pix_valid}, 32'd1);
            chk("bp_x", 32'(pix_x), 32'd2);
            chk("bp_y", 32'(pix_y), 32'd1);
            chk("bp_depth", 32'(pix_depth), 32'd6);
            chk("bp_no_start", {31'd0, calc_start}, 32'd0);
            if (k < 4) @(negedge sysclk);
        end
        @(posedge sysclk); #2 pix_ready = 1'b1;
        @(negedge sysclk);
        chk("bp_no_start_at_rise", {31'd0, calc_start}, 32'd0);
        @(negedge sysclk);
        chk("bp_restart", {31'd0, calc_start}, 32'd1);
        chk("bp_next_x", 32'(calc_x), 32'd3);
        wait_idle(200, 1'b0);

        // frame_start and input changes mid-frame are ignored
        start_frame(32'h00100000, 32'hFFF00000, 32'h00000800);
        n = 0;
        while (m_start_idx < 6 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        chk("bp_mid_frame", {31'd0, busy}, 32'd1);
        @(posedge sysclk); #2;
        frame_start = 1'b1; re_origin = 32'h12345678; step = 32'h00000100;
        @(posedge sysclk); #2 frame_start = 1'b0;
        wait_idle(200, 1'b0);

        // Wrap-around of the real part
        start_frame(32'h7FFFFFFF, 32'h00000005, 32'h00000001);
        wait_idle(200, 1'b0);

        // Reset during WAIT abandons the frame
        lat = 1000;
        start_frame(32'h00AA0000, 32'h00BB0000, 32'h00000010);
        repeat (20) @(negedge sysclk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(posedge sysclk); #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {28'd0, busy, calc_start, pix_valid, pix_last}, 32'd0);
        chk("mid_rst_calc_re", calc_re_c, 32'd0);
        chk("mid_rst_calc_im", calc_im_c, 32'd0);
        chk("mid_rst_xy", {13'd0, calc_x, calc_y}, 32'd0);
        chk("mid_rst_pix", {3'd0, pix_depth, pix_x, pix_y}, 32'd0);
        @(posedge sysclk); #2 reset = 1'b0;
        lat = 1;
        @(negedge sysclk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        start_frame(32'h0000C000, 32'h00004000, 32'h00002000);
        wait_idle(200, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
